count_bits_seq: RTL

//  Parametrised sequential bit-statistics unit with a Start/Ready handshake.

---
 rtl/count_bits_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/count_bits_seq.sv
// Sequential MSB-first bit counter (ones / zeros / leading zeros) with Start/Ready/Done handshake.
// Optional Abort input is compiled in when COUNT_BITS_ABORT_EN is defined.
module count_bits_seq #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clock,
  input  logic              reset_b,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        Mode,
  input  logic              Start,
`ifdef COUNT_BITS_ABORT_EN
  input  logic              Abort,
`endif
  output logic [CNT_W-1:0]  count,
  output logic              Ready,
  output logic              Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t             r_state, w_state_next;
  logic [DATA_W-1:0]  r_shift, w_shift_next;
  logic [CNT_W-1:0]   r_count, w_count_next;
  logic [CNT_W-1:0]   r_left,  w_left_next;
  logic [1:0]         r_mode,  w_mode_next;
  logic               w_bit;
  logic               w_rest_zero;

  assign w_bit       = r_shift[DATA_W-1];
  assign w_rest_zero = (r_shift[DATA_W-2:0] == '0);

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_count <= '0;
      r_left  <= '0;
      r_mode  <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_count <= w_count_next;
      r_left  <= w_left_next;
      r_mode  <= w_mode_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_count_next = r_count;
    w_left_next  = r_left;
    w_mode_next  = r_mode;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_shift_next = data;
          w_count_next = '0;
          w_left_next  = CNT_W'(DATA_W);
          w_mode_next  = Mode;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift_next = {r_shift[DATA_W-2:0], 1'b0};
        w_left_next  = r_left - CNT_W'(1);
        case (r_mode)
          2'b01: w_count_next = r_count + CNT_W'(~w_bit);
          2'b10: begin
            // The first one ends a leading-zero scan without being counted.
            if (w_bit) w_state_next = S_DONE;
            else       w_count_next = r_count + CNT_W'(1);
          end
          default: begin
            w_count_next = r_count + CNT_W'(w_bit);
            if (w_rest_zero) w_state_next = S_DONE;
          end
        endcase
        if (r_left == CNT_W'(1)) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
`ifdef COUNT_BITS_ABORT_EN
    // Abort outranks both completion and the Done cycle, but never idle Start.
    if (Abort && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
      w_count_next = '0;
    end
`endif
  end

  assign count = r_count;
  assign Ready = (r_state == S_IDLE);
  assign Done  = (r_state == S_DONE);

endmodule
